// File: rtl/ifu_fetch_queue.sv
// Fetch queue: in-order imem requests with up to DEPTH outstanding, buffered into DEPTH slots for decode.
// Latency 2 cycles request-to-decode at 1-cycle memory; decode stall holds the head and stops fetch once slots run out.
module ifu_fetch_queue #(
   parameter int                XLEN      = 64,
   parameter int                ILEN      = 32,
   parameter int                DEPTH     = 4,
   parameter logic [XLEN-1:0]   RESET_PC  = XLEN'(64'h8000_0000),
   parameter logic [ILEN-1:0]   NOP_INSTR = ILEN'(32'h0000_0013)
) (
   input  logic                         clk,
   input  logic                         rstn,
   input  logic                         redirect_en,
   input  logic [XLEN-1:0]              redirect_pc,
   output logic                         imem_req_valid,
   input  logic                         imem_req_ready,
   output logic [XLEN-1:0]              imem_req_addr,
   input  logic                         imem_rsp_valid,
   input  logic [ILEN-1:0]              imem_rsp_instr,
   output logic                         ifu_valid,
   input  logic                         ifu_ready,
   output logic [XLEN-1:0]              ifu_pc,
   output logic [ILEN-1:0]              ifu_instr,
   output logic [XLEN-1:0]              ifu_snxt_pc,
   output logic [$clog2(DEPTH+1)-1:0]   fq_count
);

   localparam int                PTR_W   = $clog2(DEPTH);
   localparam int                CNT_W   = $clog2(DEPTH+1);
   localparam logic [CNT_W-1:0]  DEPTH_C = CNT_W'(DEPTH);

   typedef struct packed {
      logic             alloc;
      logic             filled;
      logic [XLEN-1:0]  pc;
      logic [ILEN-1:0]  instr;
   } slot_t;

   slot_t             slot_q [DEPTH];
   logic [XLEN-1:0]   pc_q;
   logic [PTR_W-1:0]  alloc_ptr_q;
   logic [PTR_W-1:0]  fill_ptr_q;
   logic [PTR_W-1:0]  head_ptr_q;
   logic [CNT_W-1:0]  count_q;
   logic [CNT_W-1:0]  inflight_q;
   logic [CNT_W-1:0]  drop_cnt_q;
   logic [XLEN-1:0]   last_pc_q;
   logic [XLEN-1:0]   last_snxt_q;

   logic [CNT_W-1:0]  occ;
   logic              req_fire;
   logic              rsp_drop;
   logic              rsp_fill;
   logic              pop;
   slot_t             head;

   // Squashed in-flight responses still hold a credit, so they count against DEPTH.
   assign occ            = count_q + drop_cnt_q;
   assign imem_req_valid = rstn && !redirect_en && (occ < DEPTH_C);
   assign imem_req_addr  = pc_q;
   assign req_fire       = imem_req_valid && imem_req_ready;

   // A response with nothing outstanding is a protocol error and is ignored.
   assign rsp_drop = imem_rsp_valid && (drop_cnt_q != '0);
   assign rsp_fill = imem_rsp_valid && (drop_cnt_q == '0) && (inflight_q != '0);

   assign head        = slot_q[head_ptr_q];
   assign ifu_valid   = head.alloc && head.filled;
   assign pop         = ifu_valid && ifu_ready && !redirect_en;
   assign ifu_pc      = ifu_valid ? head.pc : last_pc_q;
   assign ifu_snxt_pc = ifu_valid ? head.pc + XLEN'(4) : last_snxt_q;
   assign ifu_instr   = ifu_valid ? head.instr : NOP_INSTR;
   assign fq_count    = count_q;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         for (int i = 0; i < DEPTH; i++) begin
            slot_q[i] <= '0;
         end
      end else if (redirect_en) begin
         for (int i = 0; i < DEPTH; i++) begin
            slot_q[i].alloc  <= 1'b0;
            slot_q[i].filled <= 1'b0;
         end
      end else begin
         // Pop, fill and alloc always target distinct slots, so their order here is free.
         if (pop) begin
            slot_q[head_ptr_q].alloc  <= 1'b0;
            slot_q[head_ptr_q].filled <= 1'b0;
         end
         if (rsp_fill) begin
            slot_q[fill_ptr_q].instr  <= imem_rsp_instr;
            slot_q[fill_ptr_q].filled <= 1'b1;
         end
         if (req_fire) begin
            slot_q[alloc_ptr_q].alloc  <= 1'b1;
            slot_q[alloc_ptr_q].filled <= 1'b0;
            slot_q[alloc_ptr_q].pc     <= pc_q;
         end
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         pc_q        <= RESET_PC;
         alloc_ptr_q <= '0;
         fill_ptr_q  <= '0;
         head_ptr_q  <= '0;
         count_q     <= '0;
         inflight_q  <= '0;
         drop_cnt_q  <= '0;
      end else if (redirect_en) begin
         pc_q        <= redirect_pc;
         alloc_ptr_q <= '0;
         fill_ptr_q  <= '0;
         head_ptr_q  <= '0;
         count_q     <= '0;
         inflight_q  <= '0;
         // Every unfilled slot becomes a response to throw away, less any arriving now.
         drop_cnt_q  <= drop_cnt_q + inflight_q - CNT_W'(rsp_drop | rsp_fill);
      end else begin
         if (req_fire) begin
            pc_q        <= pc_q + XLEN'(4);
            alloc_ptr_q <= alloc_ptr_q + PTR_W'(1);
         end
         if (rsp_fill) begin
            fill_ptr_q <= fill_ptr_q + PTR_W'(1);
         end
         if (pop) begin
            head_ptr_q <= head_ptr_q + PTR_W'(1);
         end
         count_q    <= count_q + CNT_W'(req_fire) - CNT_W'(pop);
         inflight_q <= inflight_q + CNT_W'(req_fire) - CNT_W'(rsp_fill);
         drop_cnt_q <= drop_cnt_q - CNT_W'(rsp_drop);
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         last_pc_q   <= '0;
         last_snxt_q <= '0;
      end else if (ifu_valid) begin
         last_pc_q   <= head.pc;
         last_snxt_q <= head.pc + XLEN'(4);
      end
   end

endmodule

// File: doc/ifu_fetch_queue.md
Name: ifu_fetch_queue

Overview:
- Parametrised successor to the single-register fetch stage.
- Issues in-order instruction fetch requests to a valid/ready instruction-memory port, with up to DEPTH requests in flight.
- Buffers returned instructions in a DEPTH-entry fetch queue and presents them to decode over a valid/ready handshake.
- On redirect (jump/flush), squashes queued entries and discards stale in-flight responses.

Parameters:
XLEN, 64, address/PC width
ILEN, 32, instruction width
DEPTH, 4, fetch-queue entries and maximum outstanding requests; power of two, >=2
RESET_PC, 64'h80000000, PC after reset
NOP_INSTR, 32'h00000013, value on ifu_instr when the queue head is not valid

Ports:
clk  input  1  clock; all state updates on rising edge
rstn  input  1  asynchronous, active-low reset
redirect_en  input  1  jump/flush; redirect fetch this cycle
redirect_pc  input  XLEN  new fetch PC
imem_req_valid  output  1  fetch request valid
imem_req_ready  input  1  memory accepts request
imem_req_addr  output  XLEN  fetch address (= pc)
imem_rsp_valid  input  1  response valid; always accepted; responses arrive in request order
imem_rsp_instr  input  ILEN  fetched instruction
ifu_valid  output  1  queue head holds a filled instruction
ifu_ready  input  1  decode accepts head; low = hazard stall
ifu_pc  output  XLEN  PC of head entry
ifu_instr  output  ILEN  instruction of head entry
ifu_snxt_pc  output  XLEN  ifu_pc + 4
fq_count  output  $clog2(DEPTH+1)  allocated queue slots

Behaviour:
- Reset (async assert, sync-safe deassert):
  - pc=RESET_PC; alloc/fill/head pointers=0; all slot valid/filled bits=0; drop_cnt=0.
  - Outputs: ifu_valid=0, ifu_pc=0, ifu_instr=NOP_INSTR, ifu_snxt_pc=0, fq_count=0, imem_req_valid=0 during reset.
  - Memory must be reset concurrently; no pre-reset responses are expected.
- Slot allocation at request:
  - imem_req_valid = !redirect_en && (fq_count + drop_cnt < DEPTH).
  - Request fires when valid & ready. On fire, write pc into slot[alloc_ptr], set allocated, alloc_ptr++, pc <= pc+4 (wraps mod 2^XLEN).
  - imem_req_addr = pc combinationally.
- Response handling:
  - If drop_cnt>0: drop_cnt--, data discarded.
  - Otherwise: slot[fill_ptr].instr <= imem_rsp_instr, mark filled, fill_ptr++.
- Output and pop:
  - ifu_valid = head slot allocated and filled. ifu_pc/ifu_instr come from the head slot; when !ifu_valid, ifu_instr=NOP_INSTR and ifu_pc holds the last head value.
  - Pop on ifu_valid & ifu_ready: clear slot, head_ptr++.
  - Stall (ifu_ready=0): head and outputs held stable; fetching continues until full.
- Full/empty:
  - Full when fq_count + drop_cnt == DEPTH; no request issued. Squashed in-flight responses occupy credit until they return.
  - Empty leaves ifu_valid=0.
- Simultaneous alloc + fill + pop in one cycle is legal; fq_count = count + alloc - pop.
- Redirect (redirect_en=1), taking priority over everything:
  - pc <= redirect_pc; all slots cleared; pointers reset to 0; no request that cycle; pop ignored.
  - drop_cnt <= drop_cnt + unfilled_allocated - (imem_rsp_valid ? 1 : 0).
  - ifu_valid=0 from the next cycle. First request to redirect_pc issues the cycle after redirect.
- Back-to-back redirects: each takes the latest redirect_pc; drop_cnt accumulates correctly.
- Throughput: with 1-cycle memory latency and ifu_ready=1, sustains one instruction per cycle after 2-cycle fill latency.
- Protocol violation: imem_rsp_valid with no outstanding request is ignored; bench flags it with an assertion.

Test Plan:
- Reset release, memory ready with 1-cycle response latency, ifu_ready=1 -> requests 0x80000000, 0x80000004, …; ifu_valid first high at cycle 2; one instruction/cycle; ifu_snxt_pc=ifu_pc+4.
- ifu_ready=0 for 10 cycles, memory always responding -> exactly DEPTH(4) requests issued, fq_count=4, imem_req_valid=0, head outputs stable; release -> in-order drain, no loss or duplication.
- Redirect to 0x80001000 with 3 requests unfilled, no response that cycle -> drop_cnt=3; next 3 responses discarded; first ifu_valid shows ifu_pc=0x80001000.
- Redirect in the same cycle as a response and a pop -> drop_cnt = unfilled-1, pop ignored, queue empty next cycle.
- imem_req_ready toggling randomly, random response latency 1-5 cycles, random ifu_ready -> decode stream equals sequential PCs/instructions from the memory model; fq_count+drop_cnt never exceeds 4.
- rstn asserted mid-stream with queue full -> all outputs at reset values immediately; after release, fetch restarts at 0x80000000.
